// File: rtl/irq_controller.sv
// Interrupt controller: N_SRC edge-triggered sources, each IDLE, PENDING or ACTIVE,
// with a small register bus for enable, status, claim and complete.
//
// Ports:
//   clk, reset_ni            - clock and synchronous active-low reset
//   sel_i, wr_en_i           - bus select (one access per selected cycle), write/read
//   address_in_i[11:0]       - register byte address
//   data_in_i[31:0]          - write data
//   data_out_o[31:0], ack_o  - registered read data and acknowledge
//   src_irq_i[N_SRC-1:0]     - per-source request levels (source 0 is the timer)
//   src_eoi_o[N_SRC-1:0]     - per-source end-of-interrupt, low while ACTIVE
//   cpu_irq_o                - registered request to the CPU
//
// Register map: 0x000 ENABLE (RW), 0x004 PENDING (RO), 0x008 ACTIVE (RO),
//               0x00C CLAIM (RO, read claims), 0x010 COMPLETE (WO, id in [4:0]).
module irq_controller #(
    parameter int unsigned N_SRC = 8
) (
    input  logic             clk,
    input  logic             reset_ni,
    input  logic             sel_i,
    input  logic             wr_en_i,
    input  logic [11:0]      address_in_i,
    input  logic [31:0]      data_in_i,
    output logic [31:0]      data_out_o,
    output logic             ack_o,
    input  logic [N_SRC-1:0] src_irq_i,
    output logic [N_SRC-1:0] src_eoi_o,
    output logic             cpu_irq_o
);

    localparam logic [11:0] AddrEnable   = 12'h000;
    localparam logic [11:0] AddrPending  = 12'h004;
    localparam logic [11:0] AddrActive   = 12'h008;
    localparam logic [11:0] AddrClaim    = 12'h00C;
    localparam logic [11:0] AddrComplete = 12'h010;

    logic [N_SRC-1:0] enable_q, enable_d;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [N_SRC-1:0] active_q, active_d;
    logic [N_SRC-1:0] irq_prev_q, irq_prev_d;
    logic [31:0]      data_out_q, data_out_d;
    logic             ack_q, ack_d;
    logic             cpu_irq_q, cpu_irq_d;

    logic             rd_acc, wr_acc;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] idle;
    logic [N_SRC-1:0] claim_cand;
    logic [N_SRC-1:0] claim_sel;
    logic [N_SRC-1:0] claim_mask;
    logic [N_SRC-1:0] cmpl_mask;
    logic [4:0]       claim_id;
    logic             claim_found;
    logic             claim_hit;
    logic             cmpl_hit;

    // Only the low N_SRC bits and the id field of the write data are meaningful.
    logic unused_data;
    assign unused_data = ^data_in_i;

    // Zero-extend a source vector to bus width (works for N_SRC == 32 too).
    function automatic logic [31:0] zext(input logic [N_SRC-1:0] v);
        logic [31:0] r;
        r = '0;
        r[N_SRC-1:0] = v;
        return r;
    endfunction

    always_comb begin
        rd_acc     = sel_i & ~wr_en_i;
        wr_acc     = sel_i & wr_en_i;
        rise       = src_irq_i & ~irq_prev_q;
        idle       = ~(pending_q | active_q);
        claim_cand = pending_q & enable_q;

        // Priority pick: scanning downward leaves the lowest qualifying index.
        claim_found = 1'b0;
        claim_id    = '0;
        claim_sel   = '0;
        for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
            if (claim_cand[i]) begin
                claim_found  = 1'b1;
                claim_id     = 5'(i);
                claim_sel    = '0;
                claim_sel[i] = 1'b1;
            end
        end

        claim_hit  = rd_acc && (address_in_i == AddrClaim) && claim_found;
        claim_mask = claim_hit ? claim_sel : '0;

        // Ids >= N_SRC match no bit and so fall away here.
        cmpl_hit  = wr_acc && (address_in_i == AddrComplete);
        cmpl_mask = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (cmpl_hit && (data_in_i[4:0] == 5'(i))) begin
                cmpl_mask[i] = 1'b1;
            end
        end
        cmpl_mask = cmpl_mask & active_q;

        // Edges only pend idle sources: edges while PENDING/ACTIVE (including one
        // coinciding with a COMPLETE) are dropped, and a same-cycle edge cannot be
        // claimed because the claim looks at the registered pending state.
        pending_d  = (pending_q & ~claim_mask) | (rise & idle);
        active_d   = (active_q & ~cmpl_mask) | claim_mask;
        enable_d   = (wr_acc && (address_in_i == AddrEnable)) ? data_in_i[N_SRC-1:0]
                                                              : enable_q;
        irq_prev_d = src_irq_i;
        cpu_irq_d  = |(pending_q & enable_q);
        ack_d      = sel_i;

        data_out_d = '0;
        if (rd_acc) begin
            unique case (address_in_i)
                AddrEnable:  data_out_d = zext(enable_q);
                AddrPending: data_out_d = zext(pending_q);
                AddrActive:  data_out_d = zext(active_q);
                AddrClaim:   data_out_d = claim_found ? {1'b1, 26'd0, claim_id} : '0;
                default:     data_out_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_ni) begin
            enable_q   <= '0;
            pending_q  <= '0;
            active_q   <= '0;
            irq_prev_q <= '0;
            data_out_q <= '0;
            ack_q      <= 1'b0;
            cpu_irq_q  <= 1'b0;
        end else begin
            enable_q   <= enable_d;
            pending_q  <= pending_d;
            active_q   <= active_d;
            irq_prev_q <= irq_prev_d;
            data_out_q <= data_out_d;
            ack_q      <= ack_d;
            cpu_irq_q  <= cpu_irq_d;
        end
    end

    assign data_out_o = data_out_q;
    assign ack_o      = ack_q;
    assign cpu_irq_o  = cpu_irq_q;
    assign src_eoi_o  = ~active_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller (N_SRC = 8): a vector table for the main
// register/interrupt flows plus hand sequences for reset, same-cycle races and a timer.
module tb_irq_controller;

    localparam logic [11:0] A_EN   = 12'h000;
    localparam logic [11:0] A_PEND = 12'h004;
    localparam logic [11:0] A_ACT  = 12'h008;
    localparam logic [11:0] A_CLM  = 12'h00C;
    localparam logic [11:0] A_CMP  = 12'h010;
    localparam int          PERIOD = 16;

    logic        clk;
    logic        reset_ni;
    logic        sel_i;
    logic        wr_en_i;
    logic [11:0] address_in_i;
    logic [31:0] data_in_i;
    logic [31:0] data_out_o;
    logic        ack_o;
    logic [7:0]  src_irq_i;
    logic [7:0]  src_eoi_o;
    logic        cpu_irq_o;

    int n_checks = 0;
    int n_errors = 0;

    irq_controller #(.N_SRC(8)) dut (
        .clk          (clk),
        .reset_ni     (reset_ni),
        .sel_i        (sel_i),
        .wr_en_i      (wr_en_i),
        .address_in_i (address_in_i),
        .data_in_i    (data_in_i),
        .data_out_o   (data_out_o),
        .ack_o        (ack_o),
        .src_irq_i    (src_irq_i),
        .src_eoi_o    (src_eoi_o),
        .cpu_irq_o    (cpu_irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sel;
        logic        wr;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [7:0]  irq;
        logic [31:0] exp_data;
        logic        exp_ack;
        logic [7:0]  exp_eoi;
        logic        exp_cpu;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic sel, input logic wr, input logic [11:0] addr,
                                input logic [31:0] wdata, input logic [7:0] irq,
                                input logic [31:0] exp_data, input logic exp_ack,
                                input logic [7:0] exp_eoi, input logic exp_cpu);
        vec_t r;
        r.sel = sel; r.wr = wr; r.addr = addr; r.wdata = wdata; r.irq = irq;
        r.exp_data = exp_data; r.exp_ack = exp_ack; r.exp_eoi = exp_eoi; r.exp_cpu = exp_cpu;
        return r;
    endfunction

    // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
    task automatic do_cycle(input logic rst_n, input logic sel, input logic wr,
                            input logic [11:0] addr, input logic [31:0] wdata,
                            input logic [7:0] irq);
        reset_ni     = rst_n;
        sel_i        = sel;
        wr_en_i      = wr;
        address_in_i = addr;
        data_in_i    = wdata;
        src_irq_i    = irq;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] d, input logic a,
                           input logic [7:0] e, input logic c);
        chk({tag, " data"}, data_out_o, d);
        chk({tag, " ack"}, {31'd0, ack_o}, {31'd0, a});
        chk({tag, " eoi"}, {24'd0, src_eoi_o}, {24'd0, e});
        chk({tag, " cpu_irq"}, {31'd0, cpu_irq_o}, {31'd0, c});
    endtask

    logic        timer_irq;
    logic        was_active;
    int          tcount;
    int          lost;
    int          serviced;
    int          next_op;

    initial begin
        // Basic flow: enable 0, pulse, pending, cpu_irq, claim, eoi low.
        vecs.push_back(mk(1, 1, A_EN,   32'h01, 8'h00, 32'h0,        1, 8'hFF, 0));
        vecs.push_back(mk(0, 0, A_EN,   32'h00, 8'h01, 32'h0,        0, 8'hFF, 0));
        vecs.push_back(mk(1, 0, A_PEND, 32'h00, 8'h00, 32'h01,       1, 8'hFF, 1));
        vecs.push_back(mk(1, 0, A_CLM,  32'h00, 8'h00, 32'h80000000, 1, 8'hFE, 1));
        vecs.push_back(mk(0, 0, A_EN,   32'h00, 8'h00, 32'h0,        0, 8'hFE, 0));
        vecs.push_back(mk(1, 0, A_ACT,  32'h00, 8'h00, 32'h01,       1, 8'hFE, 0));
        // Complete with level held high: no re-pend until a new edge.
        vecs.push_back(mk(0, 0, A_EN,   32'h00, 8'h01, 32'h0,        0, 8'hFE, 0));
        vecs.push_back(mk(1, 1, A_CMP,  32'h00, 8'h01, 32'h0,        1, 8'hFF, 0));
        vecs.push_back(mk(0, 0, A_EN,   32'h00, 8'h01, 32'h0,        0, 8'hFF, 0));
        vecs.push_back(mk(1, 0, A_PEND, 32'h00, 8'h00, 32'h00,       1, 8'hFF, 0));
        vecs.push_back(mk(0, 0, A_EN,   32'h00, 8'h01, 32'h0,        0, 8'hFF, 0));
        vecs.push_back(mk(1, 0, A_PEND, 32'h00, 8'h00, 32'h01,       1, 8'hFF, 1));
        vecs.push_back(mk(1, 0, A_CLM,  32'h00, 8'h00, 32'h80000000, 1, 8'hFE, 1));
        vecs.push_back(mk(1, 1, A_CMP,  32'h00, 8'h00, 32'h0,        1, 8'hFF, 0));
        // Priority between sources 2 and 3.
        vecs.push_back(mk(1, 1, A_EN,   32'h0C, 8'h00, 32'h0,        1, 8'hFF, 0));
        vecs.push_back(mk(0, 0, A_EN,   32'h00, 8'h0C, 32'h0,        0, 8'hFF, 0));
        vecs.push_back(mk(1, 0, A_CLM,  32'h00, 8'h00, 32'h80000002, 1, 8'hFB, 1));
        vecs.push_back(mk(1, 0, A_CLM,  32'h00, 8'h00, 32'h80000003, 1, 8'hF3, 1));
        vecs.push_back(mk(1, 0, A_CLM,  32'h00, 8'h00, 32'h00000000, 1, 8'hF3, 0));
        vecs.push_back(mk(1, 1, A_CMP,  32'h02, 8'h00, 32'h0,        1, 8'hF7, 0));
        vecs.push_back(mk(1, 1, A_CMP,  32'h03, 8'h00, 32'h0,        1, 8'hFF, 0));
        // Disabled source 5 pends but does not interrupt until enabled.
        vecs.push_back(mk(0, 0, A_EN,   32'h00, 8'h20, 32'h0,        0, 8'hFF, 0));
        vecs.push_back(mk(1, 0, A_PEND, 32'h00, 8'h00, 32'h20,       1, 8'hFF, 0));
        vecs.push_back(mk(1, 0, A_CLM,  32'h00, 8'h00, 32'h0,        1, 8'hFF, 0));
        vecs.push_back(mk(1, 1, A_EN,   32'h20, 8'h00, 32'h0,        1, 8'hFF, 0));
        vecs.push_back(mk(0, 0, A_EN,   32'h00, 8'h00, 32'h0,        0, 8'hFF, 1));
        vecs.push_back(mk(1, 0, A_CLM,  32'h00, 8'h00, 32'h80000005, 1, 8'hDF, 1));
        vecs.push_back(mk(1, 1, A_CMP,  32'h05, 8'h00, 32'h0,        1, 8'hFF, 0));
        // Bogus completes and register map corners with source 1 left ACTIVE.
        vecs.push_back(mk(1, 1, A_EN,   32'hFF, 8'h00, 32'h0,        1, 8'hFF, 0));
        vecs.push_back(mk(0, 0, A_EN,   32'h00, 8'h02, 32'h0,        0, 8'hFF, 0));
        vecs.push_back(mk(1, 0, A_CLM,  32'h00, 8'h00, 32'h80000001, 1, 8'hFD, 1));
        vecs.push_back(mk(1, 1, A_CMP,  32'h07, 8'h00, 32'h0,        1, 8'hFD, 0));
        vecs.push_back(mk(1, 1, A_CMP,  32'h1F, 8'h00, 32'h0,        1, 8'hFD, 0));
        vecs.push_back(mk(1, 0, A_ACT,  32'h00, 8'h00, 32'h02,       1, 8'hFD, 0));
        vecs.push_back(mk(1, 0, A_EN,   32'h00, 8'h00, 32'hFF,       1, 8'hFD, 0));
        vecs.push_back(mk(1, 0, 12'h014, 32'h0, 8'h00, 32'h0,        1, 8'hFD, 0));
        vecs.push_back(mk(1, 1, A_PEND, 32'hFF, 8'h00, 32'h0,        1, 8'hFD, 0));
        vecs.push_back(mk(1, 0, A_PEND, 32'h00, 8'h00, 32'h0,        1, 8'hFD, 0));
        vecs.push_back(mk(1, 0, A_CMP,  32'h00, 8'h00, 32'h0,        1, 8'hFD, 0));

        // Reset.
        do_cycle(0, 0, 0, A_EN, 32'h0, 8'h00);
        do_cycle(0, 0, 0, A_EN, 32'h0, 8'h00);
        chk_all("reset", 32'h0, 0, 8'hFF, 0);

        foreach (vecs[i]) begin
            do_cycle(1, vecs[i].sel, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].irq);
            chk_all($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_ack,
                    vecs[i].exp_eoi, vecs[i].exp_cpu);
        end

        // Reset mid-service beats a concurrent write; source 1 held high through reset.
        do_cycle(0, 1, 1, A_EN, 32'hFF, 8'h02);
        chk_all("rst_mid", 32'h0, 0, 8'hFF, 0);
        do_cycle(1, 0, 0, A_EN, 32'h0, 8'h02);
        chk("rst_rel cpu_irq", {31'd0, cpu_irq_o}, 32'h0);
        do_cycle(1, 1, 0, A_EN, 32'h0, 8'h02);
        chk("rst enable", data_out_o, 32'h0);
        do_cycle(1, 1, 0, A_PEND, 32'h0, 8'h02);
        chk("rst held edge pend", data_out_o, 32'h02);
        do_cycle(1, 1, 0, A_ACT, 32'h0, 8'h02);
        chk("rst active", data_out_o, 32'h0);

        // Edge coinciding with a CLAIM is not claimable that cycle.
        do_cycle(1, 1, 1, A_EN, 32'h04, 8'h02);
        do_cycle(1, 1, 0, A_CLM, 32'h0, 8'h06);
        chk("race claim", data_out_o, 32'h0);
        do_cycle(1, 1, 0, A_PEND, 32'h0, 8'h06);
        chk("race pend", data_out_o, 32'h06);
        chk("race cpu_irq", {31'd0, cpu_irq_o}, 32'h1);
        do_cycle(1, 1, 0, A_CLM, 32'h0, 8'h06);
        chk("race claim2", data_out_o, 32'h80000002);
        // Edge coinciding with its own COMPLETE is dropped.
        do_cycle(1, 0, 0, A_EN, 32'h0, 8'h02);
        do_cycle(1, 1, 1, A_CMP, 32'h02, 8'h06);
        chk("cmpl edge eoi", {24'd0, src_eoi_o}, 32'hFF);
        do_cycle(1, 1, 0, A_PEND, 32'h0, 8'h06);
        chk("cmpl edge pend", data_out_o, 32'h02);
        do_cycle(1, 1, 0, A_ACT, 32'h0, 8'h00);
        chk("cmpl edge act", data_out_o, 32'h0);

        // Timer on source 0 serviced by a polled handler over three periods.
        do_cycle(1, 1, 1, A_EN, 32'h01, 8'h00);
        timer_irq  = 1'b0;
        was_active = 1'b0;
        tcount     = 0;
        lost       = 0;
        serviced   = 0;
        next_op    = 0;
        for (int cyc = 0; cyc < 3 * PERIOD + 8; cyc++) begin
            case (next_op)
                1:       do_cycle(1, 1, 0, A_CLM, 32'h0, {7'd0, timer_irq});
                2:       do_cycle(1, 1, 1, A_CMP, 32'h0, {7'd0, timer_irq});
                default: do_cycle(1, 0, 0, A_EN, 32'h0, {7'd0, timer_irq});
            endcase
            if (next_op == 1) begin
                chk("timer claim", data_out_o, 32'h80000000);
                chk("timer eoi low", {31'd0, src_eoi_o[0]}, 32'h0);
                next_op = 2;
            end else if (next_op == 2) begin
                chk("timer eoi high", {31'd0, src_eoi_o[0]}, 32'h1);
                serviced++;
                next_op = 0;
            end else if (cpu_irq_o) begin
                next_op = 1;
            end
            if (!src_eoi_o[0]) was_active = 1'b1;
            if (was_active && src_eoi_o[0]) begin
                timer_irq  = 1'b0;
                was_active = 1'b0;
            end
            tcount++;
            if (tcount == PERIOD) begin
                tcount = 0;
                if (timer_irq) begin
                    lost++;
                    $display("FAIL timer lost interrupt at cycle %0d: irq still %0d, required 0",
                             cyc, timer_irq);
                end
                timer_irq = 1'b1;
            end
        end
        chk("timer serviced", serviced, 3);
        chk("timer lost", lost, 0);
        chk("timer irq dropped", {31'd0, timer_irq}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/irq_controller.md
IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 The block SHALL have parameter N_SRC, default 8, meaning the number of interrupt sources (legal range 1..32).
REQ-002 The block SHALL have port clk, input, 1, the single clock; every register SHALL update on its rising edge.
REQ-003 The block SHALL have port reset_ni, input, 1, a synchronous active-low reset, sampled on the rising edge of clk.
REQ-004 The block SHALL have port sel_i, input, 1, bus select; each cycle it is high is one access.
REQ-005 The block SHALL have port wr_en_i, input, 1, bus write (1) or read (0).
REQ-006 The block SHALL have port address_in_i, input, 12, the register byte address.
REQ-007 The block SHALL have port data_in_i, input, 32, bus write data.
REQ-008 The block SHALL have port data_out_o, output, 32, registered bus read data.
REQ-009 The block SHALL have port ack_o, output, 1, registered bus acknowledge.
REQ-010 The block SHALL have port src_irq_i, input, N_SRC, per-source interrupt request levels (source 0 is the timer).
REQ-011 The block SHALL have port src_eoi_o, output, N_SRC, per-source end-of-interrupt level; 1 = idle or done, 0 = in service.
REQ-012 The block SHALL have port cpu_irq_o, output, 1, registered interrupt request to the CPU.

Function
REQ-013 Each cycle with sel_i=1, the block SHALL drive ack_o=1 in the next cycle; otherwise ack_o SHALL be 0; unmapped addresses SHALL be acked, writes to them ignored, reads returning 0.
REQ-014 The next-cycle data_out_o SHALL be 0 except for a read of a mapped readable register.
REQ-015 The register map SHALL be: 0x000 ENABLE (RW, bits [N_SRC-1:0]), 0x004 PENDING (RO), 0x008 ACTIVE (RO), 0x00C CLAIM (RO, read side effect), 0x010 COMPLETE (WO, id in data_in_i[4:0]); unused bits SHALL read 0 and writes to RO registers SHALL be ignored.
REQ-016 The block SHALL register src_irq_i as irq_prev each cycle and detect a rising edge as src_irq_i & ~irq_prev.
REQ-017 Each source SHALL be in one of three states: IDLE (src_eoi_o=1), PENDING (src_eoi_o=1), or ACTIVE (src_eoi_o=0).
REQ-018 A rising edge in IDLE SHALL move the source to PENDING, whether or not it is enabled.
REQ-019 A rising edge in PENDING or ACTIVE SHALL be ignored, with no queuing.
REQ-020 A CLAIM read SHALL select the lowest-index source that is PENDING and enabled, move it to ACTIVE, and return {bit31=1, bits[4:0]=id}.
REQ-021 If no source qualifies, a CLAIM read SHALL return 0 and change no state.
REQ-022 A COMPLETE write with an id that is ACTIVE SHALL return that source to IDLE with src_eoi_o=1 from the next cycle.
REQ-023 A COMPLETE write with id >= N_SRC, or with an id that is not ACTIVE, SHALL be ignored.
REQ-024 A source's level staying high after COMPLETE SHALL NOT re-pend it; only a new rising edge SHALL.
REQ-025 State transitions and src_eoi_o SHALL take effect one cycle after the causing edge or access; ACTIVE/PENDING reads SHALL reflect state before the access.
REQ-026 The block SHALL drive cpu_irq_o as the registered value of |(PENDING & ENABLE), giving 1 cycle latency from a PENDING/ENABLE change; ACTIVE sources SHALL NOT hold cpu_irq_o high.
REQ-027 A rising edge on source k in the same cycle as a CLAIM SHALL NOT let the CLAIM select k; k SHALL become PENDING in the next cycle.
REQ-028 A COMPLETE for k and a rising edge on k in the same cycle SHALL leave k IDLE (edge dropped).
REQ-029 Clearing an ENABLE bit SHALL NOT affect PENDING or ACTIVE state for that source; pending state SHALL be retained until the bit is re-enabled and the source claimed.

Reset
REQ-030 On reset_ni=0 at a clk edge, the block SHALL set ENABLE=0, all sources IDLE, irq_prev=0, src_eoi_o all 1, cpu_irq_o=0, ack_o=0, and data_out_o=0.
REQ-031 Reset SHALL take priority over any concurrent bus access or edge, including mid-service.
REQ-032 A source held high through reset release SHALL count as a rising edge in the first cycle after reset.

Verification
REQ-033 The bench SHALL cover: write ENABLE=0x01, then pulse src_irq_i[0] -> PENDING=0x01 next cycle, then cpu_irq_o=1 one cycle later; CLAIM -> 0x80000000; src_eoi_o[0]=0; cpu_irq_o falls.
REQ-034 The bench SHALL cover: with source 0 ACTIVE, write COMPLETE id=0 -> src_eoi_o[0]=1 next cycle; src_irq_i[0] held high one more cycle -> no re-pend; the next rising edge -> PENDING.
REQ-035 The bench SHALL cover: ENABLE=0x0C, edges on sources 2 and 3 -> CLAIM returns 0x80000002, then 0x80000003, then 0x00000000.
REQ-036 The bench SHALL cover: edge on disabled source 5 -> PENDING=0x20, cpu_irq_o=0, CLAIM=0; write ENABLE=0x20 -> cpu_irq_o=1 after 2 cycles.
REQ-037 The bench SHALL cover: COMPLETE id=7 with source 7 IDLE, and COMPLETE id=31 -> no state change.
REQ-038 The bench SHALL cover: reset asserted with source 1 ACTIVE -> src_eoi_o all 1 and ENABLE=0.
REQ-039 The bench SHALL cover: a timer source connected to src_irq_i[0]/src_eoi_o[0] -> timer irq drops after COMPLETE, with no lost-interrupt message across 3 periods.
